// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - Fibonacci LFSR bit-sequence generator (optional checks: LFSR_GEN_CHECK_EN)
module lfsr_gen #(
    parameter int             N               = 31,
    parameter logic [N-1:0]   TAPS            = N'(9),
    parameter logic [N-1:0]   START_VALUE     = N'(1),
    parameter bit             VARIABLE_CONFIG = 1'b0
) (
    input  logic         clk_i,
    input  logic         reset_ni,
    input  logic         load_config_i,
    input  logic [N-1:0] taps_i,
    input  logic [N-1:0] start_value_i,
    output logic         data_o,
    output logic         valid_o
);

    logic [N-1:0] state;
    logic [N-1:0] taps_r;
    logic [N-1:0] state_nxt;
    logic [N-1:0] taps_nxt;
    logic         valid_nxt;
    logic [N-1:0] load_taps;
    logic [N-1:0] load_start;
    logic         fb;

    // A fixed-config build ignores the run-time inputs and reloads the parameters.
    assign load_taps  = VARIABLE_CONFIG ? taps_i        : TAPS;
    assign load_start = VARIABLE_CONFIG ? start_value_i : START_VALUE;

    // x(n+N) is the parity of the tapped terms x(n+k).
    assign fb     = ^(state & taps_r);
    assign data_o = state[0];

    // Next state: load wins; the first cycle after reset only raises valid so x(0) is seen.
    always_comb begin
        state_nxt = state;
        taps_nxt  = taps_r;
        valid_nxt = valid_o;
        if (load_config_i) begin
            state_nxt = load_start;
            taps_nxt  = load_taps;
            valid_nxt = 1'b1;
        end else if (!valid_o) begin
            valid_nxt = 1'b1;
        end else begin
            state_nxt = {fb, state[N-1:1]};
        end
    end

    // State registers; reset restores the power-on configuration and drops valid.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state   <= START_VALUE;
            taps_r  <= TAPS;
            valid_o <= 1'b0;
        end else begin
            state   <= state_nxt;
            taps_r  <= taps_nxt;
            valid_o <= valid_nxt;
        end
    end

`ifdef LFSR_GEN_CHECK_EN
    // Flag configurations that lock the register at zero or never feed back.
    always @(posedge clk_i) begin
        if (reset_ni) begin
            if (load_config_i && (load_start == '0))
                $error("lfsr_gen: load of all-zero start value");
            if (load_config_i && (load_taps == '0))
                $error("lfsr_gen: load of all-zero tap mask");
            if (valid_o && (state == '0))
                $error("lfsr_gen: state is zero while valid");
        end
    end
`else
    // No run-time checks in this build; ports and timing are unchanged.
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// tb/tb_lfsr_gen.sv - randomized self-checking bench for lfsr_gen against a recurrence model
module tb_lfsr_gen;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic        load0, load1, load2;
    logic [30:0] taps_w, start_w;
    logic [4:0]  taps_b, start_b;
    logic        d0, v0, d1, v1, d2, v2;

    always #5 clk_i = ~clk_i;

    lfsr_gen dut0 (
        .clk_i(clk_i), .reset_ni(reset_ni), .load_config_i(load0),
        .taps_i(taps_w), .start_value_i(start_w), .data_o(d0), .valid_o(v0)
    );

    lfsr_gen #(.N(5), .TAPS(5'b00101), .START_VALUE(5'd1)) dut1 (
        .clk_i(clk_i), .reset_ni(reset_ni), .load_config_i(load1),
        .taps_i(taps_b), .start_value_i(start_b), .data_o(d1), .valid_o(v1)
    );

    lfsr_gen #(.VARIABLE_CONFIG(1'b1)) dut2 (
        .clk_i(clk_i), .reset_ni(reset_ni), .load_config_i(load2),
        .taps_i(taps_w), .start_value_i(start_w), .data_o(d2), .valid_o(v2)
    );

    int passed = 0;
    int total  = 0;

    bit seq [3][4096];
    int idx [3];
    bit vexp[3];
    bit obs1[62];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Whole sequence from the recurrence x(j) = XOR of x(j-n+k) over set taps k.
    task automatic gen_seq(input int d, input int n, input logic [63:0] taps, input logic [63:0] start);
        for (int j = 0; j < 4096; j++) begin
            if (j < n) begin
                seq[d][j] = start[j];
            end else begin
                bit b = 1'b0;
                for (int k = 0; k < n; k++)
                    if (taps[k]) b ^= seq[d][j-n+k];
                seq[d][j] = b;
            end
        end
    endtask

    task automatic gen_default(input int d);
        if (d == 1) gen_seq(1, 5, 64'b00101, 64'd1);
        else        gen_seq(d, 31, 64'h9, 64'd1);
    endtask

    task automatic reset_model();
        for (int d = 0; d < 3; d++) begin
            gen_default(d);
            idx[d]  = 0;
            vexp[d] = 1'b0;
        end
    endtask

    task automatic compare_all(input string ph);
        check({ph, "_v0"}, v0, vexp[0]);
        check({ph, "_d0"}, d0, seq[0][idx[0]]);
        check({ph, "_v1"}, v1, vexp[1]);
        check({ph, "_d1"}, d1, seq[1][idx[1]]);
        check({ph, "_v2"}, v2, vexp[2]);
        check({ph, "_d2"}, d2, seq[2][idx[2]]);
    endtask

    // One clock: advance the model from the inputs that were applied at that edge, then compare.
    task automatic step(input string ph);
        logic ld;
        @(posedge clk_i);
        #1;
        if (!reset_ni) begin
            reset_model();
        end else begin
            for (int d = 0; d < 3; d++) begin
                ld = (d == 0) ? load0 : (d == 1) ? load1 : load2;
                if (ld) begin
                    if (d == 2) gen_seq(2, 31, 64'(taps_w), 64'(start_w));
                    else        gen_default(d);
                    idx[d]  = 0;
                    vexp[d] = 1'b1;
                end else if (!vexp[d]) begin
                    vexp[d] = 1'b1;
                end else begin
                    idx[d]++;
                end
            end
        end
        compare_all(ph);
    endtask

    initial begin
        int ones, zeros, gap;
        reset_ni = 1'b0;
        load0 = 1'b0; load1 = 1'b0; load2 = 1'b0;
        taps_w = '0; start_w = '0; taps_b = '0; start_b = '0;
        reset_model();
        #12;
        compare_all("rst");
        reset_ni = 1'b1;

        // Free run from reset: default 31-bit sequence and 5-bit m-sequence.
        ones = 0; zeros = 0;
        for (int i = 0; i < 70; i++) begin
            step("run");
            if (i < 62) obs1[i] = d1;
            if (i < 31) ones += int'(d1);
            if (i >= 1 && i <= 30) zeros += int'(!d0);
            if (i == 0)  check("x0_is_1", d0, 1);
            if (i == 31) check("x31_is_1", d0, 1);
            if (i == 32) check("x32_is_0", d0, 0);
            if (i == 59) check("x59_is_1", d0, 1);
        end
        check("zeros_x1_x30", zeros, 30);
        check("ones_per_period", ones, 16);
        for (int i = 31; i < 62; i++)
            check("period31", obs1[i], obs1[i-31]);

        // Zero start value locks the register at zero.
        taps_w = 31'b1111; start_w = '0; load2 = 1'b1;
        step("zload");
        load2 = 1'b0;
        repeat (40) step("zlock");
        check("zlock_d2", d2, 0);
        start_w = 31'd1; load2 = 1'b1;
        step("load1111");
        load2 = 1'b0;
        for (int i = 1; i <= 31; i++) step("run1111");
        check("x31_1111", d2, 1);

        // Randomized reloads, each repeated 10 cycles later with the same config.
        for (int it = 0; it < 12; it++) begin
            gap = $urandom_range(40, 3);
            repeat (gap) step("gap");
            taps_w  = 31'($urandom);
            start_w = 31'($urandom);
            taps_b  = 5'($urandom);
            start_b = 5'($urandom);
            for (int rep = 0; rep < 2; rep++) begin
                load0 = 1'b1;
                load1 = 1'($urandom);
                load2 = 1'b1;
                step("rload");
                load0 = 1'b0; load1 = 1'b0; load2 = 1'b0;
                repeat (9) step("rrun");
                taps_w  = (rep == 0) ? taps_w  : 31'($urandom);
            end
        end

        // Asynchronous reset in the middle of a cycle, with a load held during reset.
        @(posedge clk_i);
        #3;
        reset_ni = 1'b0;
        load2 = 1'b1;
        #1;
        reset_model();
        compare_all("async");
        step("inrst");
        load2 = 1'b0;
        #2;
        reset_ni = 1'b1;
        repeat (40) step("post");

        // Load on the first edge after reset release.
        reset_ni = 1'b0;
        #1;
        reset_model();
        compare_all("rst2");
        #2;
        reset_ni = 1'b1;
        taps_w  = 31'($urandom) | 31'd1;
        start_w = 31'($urandom) | 31'd1;
        load2 = 1'b1;
        step("ldrel");
        load2 = 1'b0;
        repeat (40) step("ldrun");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/lfsr_gen.md
LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 SHALL have parameter N, default 31: register length in bits (2..64).
REQ-002 SHALL have parameter TAPS, default 'h9, N bits wide: power-on/reset tap mask; bit k set means term x(n+k) is in the feedback.
REQ-003 SHALL have parameter START_VALUE, default 1, N bits wide: power-on/reset state.
REQ-004 SHALL have parameter VARIABLE_CONFIG, default 0: when 1, taps and start value are run-time loadable.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-006 SHALL have port reset_ni, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port load_config_i, input, 1 bit: synchronous configuration load / restart.
REQ-008 SHALL have port taps_i, input, N bits: run-time tap mask, same encoding as TAPS.
REQ-009 SHALL have port start_value_i, input, N bits: run-time initial state; bit k = x(k).
REQ-010 SHALL have port data_o, output, 1 bit: current sequence bit x(n).
REQ-011 SHALL have port valid_o, output, 1 bit: data_o holds a valid sequence bit.

Function
REQ-012 SHALL be a Fibonacci LFSR with internal registers state[N-1:0] and taps_r[N-1:0], where state[k] holds x(n+k).
REQ-013 SHALL drive data_o combinationally as state[0].
REQ-014 SHALL compute fb as the XOR over k of (state[k] AND taps_r[k]), so that x(n+N) = XOR of x(n+k) for every set tap bit k.
REQ-015 SHALL shift on an advance as state <= {fb, state[N-1:1]}, producing exactly one new bit per clock.
REQ-016 SHALL, with VARIABLE_CONFIG=1 and load_config_i=1 at an edge, set taps_r <= taps_i, state <= start_value_i and valid_o <= 1, with no shift in that cycle.
REQ-017 SHALL, with VARIABLE_CONFIG=0 and load_config_i=1 at an edge, set taps_r <= TAPS, state <= START_VALUE and valid_o <= 1, ignoring taps_i and start_value_i.
REQ-018 SHALL, with load_config_i=0 and valid_o=0, set valid_o <= 1 and hold state, so that x(0) is presented first.
REQ-019 SHALL, with load_config_i=0 and valid_o=1, shift per REQ-015 and keep valid_o at 1.
REQ-020 SHALL give load priority over shifting; load with reset deasserted in the same edge SHALL perform the load.
REQ-021 SHALL present x(0) one cycle after a load edge and x(m) m cycles after that.
REQ-022 SHALL keep an all-zero state at zero indefinitely, with no lock-up recovery.
REQ-023 SHALL accept any tap mask, including non-maximal masks, without special handling.

Reset
REQ-024 SHALL, while reset_ni=0, immediately force state=START_VALUE, taps_r=TAPS and valid_o=0, so data_o=START_VALUE[0].
REQ-025 SHALL, when reset is asserted mid-sequence, discard the sequence; after release the sequence restarts from x(0) per REQ-018.

Configuration
REQ-026 SHALL, when macro LFSR_GEN_CHECK_EN is defined, add simulation-only checks that report an error when a load applies an all-zero start value or all-zero taps, or when state is zero while valid_o=1.
REQ-027 SHALL, without LFSR_GEN_CHECK_EN, contain no checks, with identical ports and cycle behaviour.

Verification
REQ-028 N=31, TAPS='h9, START_VALUE=1, release reset -> first valid data_o=1, then 30 zeros, then x(31)=1, x(32)=0, x(59)=1.
REQ-029 N=5, TAPS='b00101, START_VALUE=1, run 62 valid cycles -> sequence periodic with period 31, containing 16 ones per period.
REQ-030 VARIABLE_CONFIG=1, load taps_i='b1111 and start_value_i=0 -> data_o=0 and valid_o=1 forever; then load start_value_i=1 -> x(0..30)=1,0,...,0 and x(31)=1.
REQ-031 Pulse load_config_i mid-run, then a second time 10 cycles later -> each time the sequence restarts at x(0) on the next cycle, identical to the first run.
REQ-032 Assert reset_ni=0 asynchronously mid-cycle -> valid_o=0 and data_o=START_VALUE[0] immediately; after release, a valid x(0) follows after one edge.
